// File: rtl/mio_bus_responder_pkg.sv
// Shared address map, target/state enums and address decoder for the MIO responder.
package mio_pkg;

    localparam logic [31:0] IO_BASE       = 32'hF000_0000;
    localparam logic [31:0] GPIO_OUT_ADDR = IO_BASE;
    localparam logic [31:0] GPIO_IN_ADDR  = IO_BASE + 32'd4;
    localparam logic [31:0] CNT_ADDR      = IO_BASE + 32'd8;

    typedef enum logic [2:0] {
        T_RAM,
        T_GPIO_OUT,
        T_GPIO_IN,
        T_CNT,
        T_NONE
    } target_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Byte-offset bits are masked off so sub-word addresses alias onto their word.
    function automatic target_e decodeAddr(input logic [31:0] addr, input int unsigned ramAw);
        logic [31:0] word;
        word = addr & ~32'h3;
        if (word == GPIO_OUT_ADDR) return T_GPIO_OUT;
        if (word == GPIO_IN_ADDR)  return T_GPIO_IN;
        if (word == CNT_ADDR)      return T_CNT;
        if ((word >> (ramAw + 2)) == 32'd0) return T_RAM;
        return T_NONE;
    endfunction

endpackage

// File: rtl/mio_bus_responder_if.sv
// CPU-side MIO request/response bundle; cpu_be exists only when MIO_BYTE_EN is defined.
interface mio_bus_responder_if;
    logic        cpu_mio;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        mio_ready;
`ifdef MIO_BYTE_EN
    logic [3:0]  cpu_be;
`endif

    modport master (
`ifdef MIO_BYTE_EN
        output cpu_be,
`endif
        output cpu_mio, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, mio_ready
    );

    modport slave (
`ifdef MIO_BYTE_EN
        input  cpu_be,
`endif
        input  cpu_mio, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, mio_ready
    );
endinterface

// File: rtl/mio_bus_responder_data_ram.sv
// Single-port synchronous word RAM (read-first); byte write enables when MIO_BYTE_EN is defined.
module mio_data_ram #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          we,
`ifdef MIO_BYTE_EN
    input  logic [3:0]    be,
`endif
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
`ifdef MIO_BYTE_EN
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
`else
            mem[addr] <= wdata;
`endif
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mio_bus_responder.sv
// MIO data-side responder: RAM with wait states, GPIO registers and a free-running counter.
// Optional byte-enable writes are controlled by the MIO_BYTE_EN macro.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int unsigned RAM_AW      = 10,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] GPIO_RESET  = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    mio_bus_responder_if.slave  bus,
    input  logic [31:0]         gpio_in,
    output logic [31:0]         gpio_out,
    output logic                bus_err
);

    state_e            state, nextState;
    target_e           tgtIn, tgtQ, tgtSel;
    logic              weQ;
    logic [31:0]       wdataQ;
    logic [RAM_AW-1:0] addrQ, ramAddr;
    logic [3:0]        waitCnt;
    logic [31:0]       cnt, rdReg, ramDout;
    logic              commit, ramWe;
`ifdef MIO_BYTE_EN
    logic [3:0]        beQ;
`endif

    assign tgtIn = decodeAddr(bus.cpu_addr, RAM_AW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (bus.cpu_mio) nextState = (tgtIn == T_RAM && WAIT_STATES != 0) ? WAIT : RESP;
            WAIT: if (waitCnt == '0) nextState = RESP;
            RESP: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // In IDLE the RAM sees the live address so a zero-wait read is ready on entry to RESP.
    always_comb begin
        bus.mio_ready = (state == RESP);
        ramAddr       = (state == IDLE) ? bus.cpu_addr[RAM_AW+1:2] : addrQ;
        tgtSel        = (state == IDLE) ? tgtIn : tgtQ;
        commit        = (state == RESP) && weQ;
        ramWe         = commit && (tgtQ == T_RAM);
        bus.cpu_rdata = '0;
        if (state == RESP) bus.cpu_rdata = (tgtQ == T_RAM) ? ramDout : rdReg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgtQ    <= T_NONE;
            weQ     <= 1'b0;
            wdataQ  <= '0;
            addrQ   <= '0;
            waitCnt <= '0;
            rdReg   <= '0;
`ifdef MIO_BYTE_EN
            beQ     <= '0;
`endif
        end else begin
            if (state == IDLE && bus.cpu_mio) begin
                tgtQ    <= tgtIn;
                weQ     <= bus.cpu_we;
                wdataQ  <= bus.cpu_wdata;
                addrQ   <= bus.cpu_addr[RAM_AW+1:2];
                waitCnt <= 4'(WAIT_STATES - 1);
`ifdef MIO_BYTE_EN
                beQ     <= bus.cpu_be;
`endif
            end else if (state == WAIT) begin
                waitCnt <= waitCnt - 4'd1;
            end
            if (nextState == RESP) begin
                case (tgtSel)
                    T_GPIO_OUT: rdReg <= gpio_out;
                    T_GPIO_IN:  rdReg <= gpio_in;
                    T_CNT:      rdReg <= cnt;
                    default:    rdReg <= '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_out <= GPIO_RESET;
            cnt      <= '0;
            bus_err  <= 1'b0;
        end else begin
            cnt <= (commit && tgtQ == T_CNT) ? wdataQ : cnt + 32'd1;
            if (commit && tgtQ == T_GPIO_OUT) begin
`ifdef MIO_BYTE_EN
                for (int unsigned i = 0; i < 4; i++) begin
                    if (beQ[i]) gpio_out[8*i +: 8] <= wdataQ[8*i +: 8];
                end
`else
                gpio_out <= wdataQ;
`endif
            end
            if (state == RESP && tgtQ == T_NONE) bus_err <= 1'b1;
        end
    end

    mio_data_ram #(.AW(RAM_AW)) uRam (
        .clk   (clk),
        .we    (ramWe),
`ifdef MIO_BYTE_EN
        .be    (beQ),
`endif
        .addr  (ramAddr),
        .wdata (wdataQ),
        .rdata (ramDout)
    );

endmodule

// File: tb/tb_mio_bus_responder.sv
// Scoreboard bench for mio_bus_responder; honours MIO_BYTE_EN when defined.
module tb_mio_bus_responder;
    localparam int unsigned W  = 2;
    localparam logic [31:0] GR = 32'h5A5A_0000;

    typedef struct {
        int unsigned cyc;
        logic        chk;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        bus_err;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    logic        doneFlag = 1'b0;

    exp_t        q[$];
    logic [31:0] ramM [int];
    logic [31:0] gpioM;
    logic        errM;
    logic [31:0] cntBase;
    int unsigned cntEdge;

    mio_bus_responder_if bus();

    mio_bus_responder #(.RAM_AW(10), .WAIT_STATES(W), .GPIO_RESET(GR)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.mio_ready === 1'b1) begin
            exp_t e;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
            end else begin
                e = q.pop_front();
                check({e.name, "_latency"}, cyc, e.cyc);
                if (e.chk) check({e.name, "_rdata"}, bus.cpu_rdata, e.rdata);
            end
        end
    end

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        bus.cpu_mio   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
`ifdef MIO_BYTE_EN
        bus.cpu_be    = be;
`endif
    endtask

    // Called at a negedge in IDLE; request is sampled at the next rising edge.
    task automatic issue(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdIn, input logic [3:0] beIn);
        exp_t        e;
        logic [31:0] word;
        logic [3:0]  be;
        int          idx;
        logic        seen;
        be   = beIn;
`ifndef MIO_BYTE_EN
        be   = 4'hF;
`endif
        word = addr & ~32'h3;
        idx  = int'(addr[11:2]);
        e.name  = name;
        e.chk   = !we;
        e.rdata = '0;
        if (addr < 32'h0000_1000) begin
            e.cyc = cyc + 1 + W;
            if (we) begin
                if (!ramM.exists(idx)) be = 4'hF;
                ramM[idx] = merge(ramM.exists(idx) ? ramM[idx] : 32'h0, wdIn, be);
            end else if (ramM.exists(idx)) begin
                e.rdata = ramM[idx];
            end else begin
                e.chk = 1'b0;
            end
        end else begin
            e.cyc = cyc + 1;
            if (word == 32'hF000_0000) begin
                if (we) gpioM = merge(gpioM, wdIn, be);
                else    e.rdata = gpioM;
            end else if (word == 32'hF000_0004) begin
                e.rdata = gpio_in;
            end else if (word == 32'hF000_0008) begin
                if (we) begin
                    cntBase = wdIn;
                    cntEdge = e.cyc + 1;
                end else begin
                    e.rdata = cntBase + (e.cyc - 1 - cntEdge);
                end
            end else begin
                errM = 1'b1;
            end
        end
        drive(we, addr, wdIn, be);
        q.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.mio_ready === 1'b1) seen = 1'b1;
        end
        bus.cpu_mio = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no ready expected ready by cycle %0d", name, e.cyc);
            q.delete();
        end
        @(negedge clk);
        check({name, "_gpio_out"}, gpio_out, gpioM);
        check({name, "_bus_err"}, {31'h0, bus_err}, {31'h0, errM});
    endtask

    task automatic releaseReset();
        rst     = 1'b1;
        cntBase = 32'h0;
        cntEdge = cyc;
        gpioM   = GR;
        errM    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        gpio_in = 32'h0;
        drive(1'b1, 32'hF000_0000, 32'h0000_00A5, 4'hF);
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", {31'h0, bus.mio_ready}, 32'h0);
            check("rst_rdata", bus.cpu_rdata, 32'h0);
            check("rst_gpio_out", gpio_out, GR);
            check("rst_bus_err", {31'h0, bus_err}, 32'h0);
        end
        releaseReset();
        issue("gpio_wr", 1'b1, 32'hF000_0000, 32'h0000_00A5, 4'hF);
        issue("gpio_rd", 1'b0, 32'hF000_0000, 32'h0, 4'hF);
        gpio_in = 32'hCAFE_F00D;
        issue("gpin_rd", 1'b0, 32'hF000_0004, 32'h0, 4'hF);
        issue("gpin_wr", 1'b1, 32'hF000_0004, 32'h1111_2222, 4'hF);
        issue("ram_wr", 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF);
        issue("ram_rd", 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        issue("cnt_wr", 1'b1, 32'hF000_0008, 32'hFFFF_FFFE, 4'hF);
        repeat (2) @(negedge clk);
        issue("cnt_wrap_rd", 1'b0, 32'hF000_0008, 32'h0, 4'hF);
        issue("unmap_rd", 1'b0, 32'h8000_0000, 32'h0, 4'hF);
        issue("unmap_wr", 1'b1, 32'h8000_0000, 32'hDEAD_0000, 4'hF);
        issue("ram_after_err", 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        issue("ram20_wr", 1'b1, 32'h0000_0020, 32'h0BAD_0020, 4'hF);

        // Reset lands in WAIT of a RAM write; that write must never commit.
        drive(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_ready", {31'h0, bus.mio_ready}, 32'h0);
        end
        bus.cpu_mio = 1'b0;
        releaseReset();
        @(negedge clk);
        issue("ram20_rd", 1'b0, 32'h0000_0020, 32'h0, 4'hF);

        for (int n = 0; n < 80; n++) begin
            int unsigned kind;
            logic [31:0] a;
            logic        we;
            kind = $urandom_range(0, 9);
            we   = 1'($urandom_range(0, 1));
            gpio_in = $urandom;
            case (kind)
                0, 1, 2, 3: a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                4:          a = 32'h0000_0FFC;
                5:          a = 32'hF000_0000 | 32'($urandom_range(0, 3));
                6:          a = 32'hF000_0004;
                7:          a = 32'hF000_0008;
                8:          a = 32'hF000_000C;
                default:    a = 32'h0000_1000 | ($urandom & 32'h7FFF_F000);
            endcase
            issue("rand", we, a, $urandom, 4'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 32'h0);
        doneFlag = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
- Data-side memory/IO responder at the far end of the CPU's MIO request interface (request, write-enable, address, write data in; read data and ready out).
- Decodes each request into one of three targets: on-chip data RAM, GPIO registers, or a cycle counter.
- Completes every request with a single-cycle ready pulse.
- RAM accesses take a configurable number of wait states, so the CPU's stall-on-not-ready path is exercised.

Parameters:
- RAM_AW, 10, RAM word-address width (RAM depth is 2^RAM_AW words).
- WAIT_STATES, 2, extra cycles inserted for a RAM access (range 0..15).
- GPIO_RESET, 32'h0000_0000, reset value of gpio_out.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- cpu_mio  input  1  request valid; held high with stable address, write-enable and write data until mio_ready.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  32  byte address; bits [1:0] are ignored.
- cpu_wdata  input  32  write data.
- cpu_rdata  output  32  read data; valid only while mio_ready=1.
- mio_ready  output  1  one-cycle completion pulse.
- gpio_in  input  32  external input word.
- gpio_out  output  32  GPIO output register.
- bus_err  output  1  sticky flag: an unmapped address was accessed.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, mio_ready=0, cpu_rdata=0, gpio_out=GPIO_RESET, counter=0, bus_err=0.
  - Any in-flight request is dropped and its pending write never commits.
  - RAM contents are not reset.
- Address map, decoded on the latched address:
  - 0x0000_0000 .. 4*2^RAM_AW-1: RAM, word index addr[RAM_AW+1:2]. The region is the upper bits zero below 0xF000_0000.
  - 0xF000_0000: gpio_out, read/write.
  - 0xF000_0004: gpio_in, read-only; writes are ignored.
  - 0xF000_0008: counter, read/write.
  - Any other address is unmapped.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If cpu_mio=1, latch cpu_addr, cpu_we and cpu_wdata.
  - RAM target with WAIT_STATES>0: go to WAIT with wait_cnt=WAIT_STATES-1.
  - Otherwise: go to RESP.
- WAIT:
  - Decrement wait_cnt each cycle.
  - When wait_cnt=0, go to RESP.
- RESP:
  - mio_ready=1 for exactly this cycle; cpu_rdata holds the target's read value.
  - Any write commits on the clock edge that ends RESP.
  - The next state is always IDLE.
- Latency from a request sampled at edge k to mio_ready high:
  - peripheral or unmapped target: cycle k+1.
  - RAM target: cycle k+1+WAIT_STATES.
- Back-to-back requests:
  - The CPU deasserts cpu_mio, or presents a new request, in the cycle after ready.
  - IDLE re-samples cpu_mio in that cycle, so peak throughput is one access per 2 cycles.
- RAM:
  - Synchronous read; the address is presented so the data is registered into cpu_rdata in RESP.
  - A read after a write to the same word returns the new data.
- Counter:
  - Increments every cycle and wraps 0xFFFF_FFFF to 0.
  - A committed write loads cpu_wdata, and load takes priority over increment on that edge.
  - A read returns the counter value at the edge that enters RESP.
- Unmapped access:
  - Completes with normal latency; read data = 0; write is discarded.
  - bus_err is set and stays set until reset.
- cpu_mio changes while in WAIT or RESP are ignored; the latched request is authoritative.

Optional Feature:
- Macro: MIO_BYTE_EN.
- Defined:
  - Adds input cpu_be[3:0], latched with the request.
  - Writes to RAM and gpio_out update only the bytes whose enable bit is 1.
  - Counter writes stay full-word.
  - cpu_be=0 turns a write into a no-op that still completes with mio_ready.
- Undefined: no cpu_be port; all writes are full 32-bit words.

Decomposition:
- Shared package mio_pkg holds:
  - address constants GPIO_OUT_ADDR, GPIO_IN_ADDR, CNT_ADDR, IO_BASE=0xF000_0000;
  - the target enum {T_RAM, T_GPIO_OUT, T_GPIO_IN, T_CNT, T_NONE};
  - the FSM state enum {IDLE, WAIT, RESP}.
- One sub-module: mio_data_ram, a single-port synchronous word RAM with write enable (byte write enables when MIO_BYTE_EN is defined).

Test Plan:
- Reset check: hold rst=0 with cpu_mio=1 → mio_ready=0, cpu_rdata=0, gpio_out=GPIO_RESET, bus_err=0. Release rst → a request is accepted on the next edge.
- RAM write then read at 0x0000_0010 with data 0x1234_5678 and WAIT_STATES=2 → each access gets mio_ready exactly 3 cycles after sampling; the read returns 0x1234_5678.
- Write 0x0000_00A5 to 0xF000_0000, then read it; set gpio_in=0xCAFE_F00D and read 0xF000_0004 → gpio_out=0xA5 from the edge ending RESP. Ready comes 1 cycle after each request; read data 0xA5 and 0xCAFE_F00D respectively.
- Write 0xFFFF_FFFE to 0xF000_0008, then idle 2 cycles → counter=0x0000_0000 after wrapping; a following read returns a small value matching the cycle count.
- Access to unmapped 0x8000_0000, first a read then a write → rdata=0 and ready after 1 cycle; bus_err=1 and stays 1 across later valid accesses.
- Pull rst low during WAIT of a RAM write to 0x0000_0020 → mio_ready never pulses; a later read of 0x0000_0020 returns its old contents.
